// File: rtl/mux_4_32_rr_arb.sv
// ---------------------------------------------------------------------------
// mux_4_32_rr_arb
//
// Round-robin burst arbiter that drives the select/enable pair of the 4:1
// 32-bit output mux. One of four requesters holds the grant for a burst. The
// grant is released on one of three events:
//   - a beat that carries last,
//   - a beat that hits the burst-length cap,
//   - the granted requester withdrawing its request.
// After a release, the priority pointer moves just past the previous holder.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req[3:0]   in   per-source request
//   last[3:0]  in   per-source end-of-burst marker (only granted bit used)
//   out_ready  in   downstream accepts the mux output this cycle
//   select     out  index of granted source (registered)
//   enable     out  mux output enable, high while a grant is held (registered)
//   grant[3:0] out  one-hot grant, zero when idle (registered)
//   beat_cnt   out  beats transferred in the current grant (registered)
// ---------------------------------------------------------------------------
module mux_4_32_rr_arb #(
  parameter int BURST_MAX = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [3:0]       last,
  input  logic             out_ready,
  output logic [1:0]       select,
  output logic             enable,
  output logic [3:0]       grant,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     state_reg;
  logic [1:0] ptr_reg;

  logic       sel_req;
  logic       beat;
  logic       release_now;
  logic [1:0] arb_base;
  logic [3:0] rot_req;
  logic       arb_found;
  logic [1:0] arb_offset;
  logic [1:0] arb_idx;

  assign sel_req = req[select];
  assign beat    = enable & out_ready & sel_req;

  // Withdrawal releases regardless of out_ready. last and the cap release
  // only on an actual beat.
  assign release_now = (state_reg == ST_GRANT) &
                       (~sel_req | (beat & (last[select] | (beat_cnt == CNT_LAST))));

  // In GRANT the only arbitration that matters happens on release, and it
  // uses the post-release order (holder + 1 first). In IDLE the stored
  // pointer is used as-is.
  assign arb_base = (state_reg == ST_GRANT) ? (select + 2'd1) : ptr_reg;

  // Rotate requests so that bit 0 is the highest-priority source.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_req[gi] = req[arb_base + 2'(gi)];
    end
  endgenerate

  always_comb begin
    arb_found  = |rot_req;
    arb_offset = 2'd0;
    // Descending scan leaves the lowest set offset.
    for (int k = 3; k >= 0; k--) begin
      if (rot_req[k]) begin
        arb_offset = 2'(k);
      end
    end
    arb_idx = arb_base + arb_offset;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= 2'd0;
      select    <= 2'd0;
      enable    <= 1'b0;
      grant     <= 4'b0000;
      beat_cnt  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arb_found) begin
            state_reg <= ST_GRANT;
            select    <= arb_idx;
            enable    <= 1'b1;
            grant     <= 4'b0001 << arb_idx;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            ptr_reg  <= select + 2'd1;
            beat_cnt <= '0;
            if (arb_found) begin
              // Back-to-back handover, no idle bubble.
              select <= arb_idx;
              grant  <= 4'b0001 << arb_idx;
            end else begin
              // select keeps its last value while idle.
              state_reg <= ST_IDLE;
              enable    <= 1'b0;
              grant     <= 4'b0000;
            end
          end else if (beat) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          enable    <= 1'b0;
          grant     <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_4_32_rr_arb.sv
// ---------------------------------------------------------------------------
// tb_mux_4_32_rr_arb
//
// Directed scenarios followed by a randomized run. The expected outputs come
// from a behavioural reference model that works on integers. Outputs are
// sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_mux_4_32_rr_arb;

  localparam int BURST_MAX = 16;
  localparam int CNT_W     = 5;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic [3:0]       last;
  logic             out_ready;
  logic [1:0]       select;
  logic             enable;
  logic [3:0]       grant;
  logic [CNT_W-1:0] beat_cnt;

  int checks;
  int errors;

  // Reference model state.
  bit m_busy;
  int m_sel;
  int m_cnt;
  int m_ptr;

  mux_4_32_rr_arb #(.BURST_MAX(BURST_MAX), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .out_ready (out_ready),
    .select    (select),
    .enable    (enable),
    .grant     (grant),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int find_winner(input logic [3:0] r, input int base);
    for (int k = 0; k < 4; k++) begin
      if (r[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_cnt  = 0;
    m_ptr  = 0;
  endtask

  // One clock cycle of the reference model for the given inputs.
  task automatic model_cycle(input logic [3:0] r, input logic [3:0] l, input logic rdy);
    int  w;
    bit  is_beat;
    bit  is_rel;
    if (!m_busy) begin
      w = find_winner(r, m_ptr);
      if (w >= 0) begin
        m_busy = 1'b1;
        m_sel  = w;
      end
    end else begin
      is_beat = rdy && r[m_sel];
      is_rel  = !r[m_sel] || (is_beat && (l[m_sel] || m_cnt == BURST_MAX - 1));
      if (is_rel) begin
        $display("burst done src=%0d beats=%0d cause=%s", m_sel,
                 is_beat ? m_cnt + 1 : m_cnt, is_beat ? "beat" : "withdraw");
        m_ptr = (m_sel + 1) % 4;
        m_cnt = 0;
        w = find_winner(r, m_ptr);
        if (w >= 0) m_sel = w;
        else        m_busy = 1'b0;
      end else if (is_beat) begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".enable"}, 32'(enable), 32'(m_busy));
    chk({tag, ".grant"}, 32'(grant), m_busy ? (32'd1 << m_sel) : 32'd0);
    chk({tag, ".select"}, 32'(select), 32'(m_sel));
    chk({tag, ".beat_cnt"}, 32'(beat_cnt), 32'(m_cnt));
  endtask

  // Apply inputs, advance one edge, compare against the model.
  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] l, input logic rdy);
    req       = r;
    last      = l;
    out_ready = rdy;
    model_cycle(r, l, rdy);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    req       = 4'b0000;
    last      = 4'b0000;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] l;
    logic       rdy;
    checks = 0;
    errors = 0;
    req = 4'b0000;
    last = 4'b0000;
    out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;

    // Reset and idle hold.
    do_reset();
    check_outputs("reset");
    for (int i = 0; i < 10; i++) step("idle", 4'b0000, 4'b0000, 1'b1);

    // Single burst from source 2, last on third beat.
    step("single_grant", 4'b0100, 4'b0000, 1'b1);
    chk("single_grant_const", 32'(grant), 32'h4);
    chk("single_select_const", 32'(select), 32'd2);
    step("single_b1", 4'b0100, 4'b0000, 1'b1);
    step("single_b2", 4'b0100, 4'b0000, 1'b1);
    chk("single_cnt2_const", 32'(beat_cnt), 32'd2);
    step("single_b3", 4'b0100, 4'b0100, 1'b1);
    chk("single_cnt_clr_const", 32'(beat_cnt), 32'd0);
    step("single_drop", 4'b0000, 4'b0000, 1'b1);
    chk("single_enable_low_const", 32'(enable), 32'd0);
    // Pointer now sits at 3: all-request picks source 3.
    step("ptr_after_single", 4'b1111, 4'b0000, 1'b0);
    chk("ptr_after_single_const", 32'(grant), 32'h8);

    // Round-robin fairness, 1-beat bursts with no bubbles.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step("rr", 4'b1111, 4'b1111, 1'b1);
      chk("rr_seq_const", 32'(grant), 32'd1 << (k % 4));
    end

    // Burst cap.
    do_reset();
    step("cap_grant", 4'b0011, 4'b0000, 1'b1);
    for (int k = 0; k < BURST_MAX - 1; k++) step("cap_beat", 4'b0011, 4'b0000, 1'b1);
    chk("cap_cnt_max_const", 32'(beat_cnt), 32'(BURST_MAX - 1));
    chk("cap_still_src0_const", 32'(grant), 32'h1);
    step("cap_release", 4'b0011, 4'b0000, 1'b1);
    chk("cap_handover_const", 32'(grant), 32'h2);

    // Backpressure then withdrawal.
    do_reset();
    step("bp_grant", 4'b0010, 4'b0000, 1'b1);
    for (int k = 0; k < 20; k++) step("bp_hold", 4'b0010, 4'b0010, 1'b0);
    chk("bp_hold_grant_const", 32'(grant), 32'h2);
    chk("bp_hold_cnt_const", 32'(beat_cnt), 32'd0);
    step("bp_withdraw", 4'b1000, 4'b0000, 1'b0);
    chk("bp_withdraw_grant_const", 32'(grant), 32'h8);
    chk("bp_withdraw_cnt_const", 32'(beat_cnt), 32'd0);

    // Asynchronous reset mid-grant, checked before any clock edge.
    step("async_pre", 4'b1000, 4'b0000, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized run with sticky requests.
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      l   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      rdy = ($urandom_range(0, 3) != 0);
      step("rand", r, l, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
